// File: rtl/aq_djpeg_pkg.sv
// Shared JPEG decoder constants and helpers: block length, zigzag-to-raster
// mapping and ring pointer sizing.
package aq_djpeg_pkg;

  localparam int unsigned ZZ_LEN = 64;

  function automatic int unsigned bank_ptr_w(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd1;
    end else begin
      return int'($clog2(n));
    end
  endfunction

  function automatic logic [5:0] zz2raster(input logic [5:0] zz);
    logic [5:0] r;
    case (zz)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aq_djpeg_coef_buffer_if.sv
// Coefficient buffer bus: Huffman-side write/commit port and iDCT-side read
// port. The decoder/test side uses master, the buffer uses slave.
interface aq_djpeg_coef_buffer_if #(
  parameter int unsigned COEF_W  = 16,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned COLOR_W = 3
);
  logic               DataInit;
  logic               DataInEnable;
  logic [5:0]         DataInAddress;
  logic [COEF_W-1:0]  DataIn;
  logic               BlockEnd;
  logic [COLOR_W-1:0] BlockColor;
  logic               DataInReady;
  logic               Overflow;
  logic               DataOutEnable;
  logic [COLOR_W-1:0] DataOutColor;
  logic [4:0]         DataOutAddress;
  logic               DataOutRead;
  logic [OUT_W-1:0]   DataOutA;
  logic [OUT_W-1:0]   DataOutB;

  modport master (
    output DataInit, DataInEnable, DataInAddress, DataIn, BlockEnd, BlockColor,
    output DataOutAddress, DataOutRead,
    input  DataInReady, Overflow, DataOutEnable, DataOutColor, DataOutA, DataOutB
  );

  modport slave (
    input  DataInit, DataInEnable, DataInAddress, DataIn, BlockEnd, BlockColor,
    input  DataOutAddress, DataOutRead,
    output DataInReady, Overflow, DataOutEnable, DataOutColor, DataOutA, DataOutB
  );
endinterface

// File: rtl/aq_djpeg_zigzag_rom.sv
// Combinational zigzag-index to raster-index lookup, shared by decoder stages.
module aq_djpeg_zigzag_rom
  import aq_djpeg_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_idx
);
  assign raster_idx = zz2raster(zz_idx);
endmodule

// File: rtl/aq_djpeg_coef_buffer.sv
// Ring of 64-entry coefficient banks between Huffman decoder and iDCT, with
// mask-based zero-fill. Define AQ_DJPEG_COEF_SAT_EN to saturate outputs.
module aq_djpeg_coef_buffer
  import aq_djpeg_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned COLOR_W   = 3
) (
  input  logic clk,
  input  logic rst,
  aq_djpeg_coef_buffer_if.slave bus
);

  localparam int unsigned PTR_W = bank_ptr_w(NUM_BANKS);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic signed [COEF_W-1:0] mem_q [NUM_BANKS][ZZ_LEN];
  logic [ZZ_LEN-1:0]  mask_q [NUM_BANKS];
  logic [ZZ_LEN-1:0]  mask_d [NUM_BANKS];
  logic [COLOR_W-1:0] tag_q  [NUM_BANKS];
  logic [COLOR_W-1:0] tag_d  [NUM_BANKS];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rdy_q, rdy_d, ovf_q, ovf_d, out_en_q, out_en_d;
  logic [COLOR_W-1:0] out_color_q, out_color_d;
  logic [OUT_W-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
  logic [5:0]         raster_s;
  logic               rel_s, in_ok_s, commit_s, mem_we_s;

  aq_djpeg_zigzag_rom u_zz_rom (
    .zz_idx     (bus.DataInAddress),
    .raster_idx (raster_s)
  );

  function automatic logic [OUT_W-1:0] conv(input logic signed [COEF_W-1:0] v);
`ifdef AQ_DJPEG_COEF_SAT_EN
    logic signed [COEF_W-1:0] hi;
    logic signed [COEF_W-1:0] lo;
    hi = {{(COEF_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    lo = {{(COEF_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (v > hi) begin
      return hi[OUT_W-1:0];
    end else if (v < lo) begin
      return lo[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  // Next-state for pointers, occupancy, masks, tags and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mask_d   = mask_q;
    tag_d    = tag_q;
    mem_we_s = 1'b0;
    commit_s = 1'b0;
    rel_s    = bus.DataOutRead && out_en_q;
    // A release in the same cycle frees a bank, so a full ring still accepts input.
    in_ok_s  = rdy_q || rel_s;
    if (bus.DataInit) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        mask_d[b] = '0;
        tag_d[b]  = '0;
      end
    end else begin
      if (rel_s) begin
        mask_d[rd_ptr_q] = '0;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Write after the release clear so it survives when both hit one bank.
      if (bus.DataInEnable && in_ok_s) begin
        mem_we_s = 1'b1;
        mask_d[wr_ptr_q][raster_s] = 1'b1;
      end else begin
        mem_we_s = 1'b0;
      end
      if (bus.BlockEnd && in_ok_s) begin
        commit_s = 1'b1;
        tag_d[wr_ptr_q] = bus.BlockColor;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        commit_s = 1'b0;
      end
      count_d = count_q + CNT_W'(commit_s) - CNT_W'(rel_s);
      if ((bus.DataInEnable || bus.BlockEnd) && !in_ok_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
    rdy_d       = (count_d < CNT_W'(NUM_BANKS));
    out_en_d    = (count_d != '0);
    out_color_d = tag_d[rd_ptr_d];
  end

  // Raster pair lookup from the head bank; unwritten slots read as zero.
  always_comb begin
    out_a_d = '0;
    out_b_d = '0;
    if (mask_q[rd_ptr_q][{1'b0, bus.DataOutAddress}]) begin
      out_a_d = conv(mem_q[rd_ptr_q][{1'b0, bus.DataOutAddress}]);
    end else begin
      out_a_d = '0;
    end
    if (mask_q[rd_ptr_q][{1'b1, bus.DataOutAddress}]) begin
      out_b_d = conv(mem_q[rd_ptr_q][{1'b1, bus.DataOutAddress}]);
    end else begin
      out_b_d = '0;
    end
  end

  // Coefficient storage; never cleared, validity lives in the masks.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q][raster_s] <= bus.DataIn;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdy_q       <= 1'b1;
      ovf_q       <= 1'b0;
      out_en_q    <= 1'b0;
      out_color_q <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        mask_q[b] <= '0;
        tag_q[b]  <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdy_q       <= rdy_d;
      ovf_q       <= ovf_d;
      out_en_q    <= out_en_d;
      out_color_q <= out_color_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      mask_q      <= mask_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.DataInReady   = rdy_q;
  assign bus.Overflow      = ovf_q;
  assign bus.DataOutEnable = out_en_q;
  assign bus.DataOutColor  = out_color_q;
  assign bus.DataOutA      = out_a_q;
  assign bus.DataOutB      = out_b_q;

endmodule

// File: tb/tb_aq_djpeg_coef_buffer.sv
// Self-checking bench for aq_djpeg_coef_buffer (NUM_BANKS=2, COEF_W=16, OUT_W=12).
module tb_aq_djpeg_coef_buffer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    int          addr;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int      exp_blk[64];
  int      zz_tab[64] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                          12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                          35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                          58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  aq_djpeg_coef_buffer_if #(.COEF_W(16), .OUT_W(12), .COLOR_W(3)) bus ();

  aq_djpeg_coef_buffer #(.NUM_BANKS(2), .COEF_W(16), .OUT_W(12), .COLOR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] tb_conv(input int v);
    logic [15:0] t;
`ifdef AQ_DJPEG_COEF_SAT_EN
    if (v > 2047) return 12'h7FF;
    if (v < -2048) return 12'h800;
`endif
    t = v[15:0];
    return t[11:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = 0;
  endtask

  task automatic wr(input int zz, input int val, input bit expect_ok);
    bus.DataInEnable  = 1'b1;
    bus.DataInAddress = zz[5:0];
    bus.DataIn        = val[15:0];
    if (expect_ok) exp_blk[zz_tab[zz]] = val;
    step();
    bus.DataInEnable = 1'b0;
  endtask

  task automatic commit(input int color);
    bus.BlockEnd   = 1'b1;
    bus.BlockColor = color[2:0];
    step();
    bus.BlockEnd = 1'b0;
  endtask

  task automatic release_blk();
    bus.DataOutRead = 1'b1;
    step();
    bus.DataOutRead = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic read_check(input string name);
    rd_exp_t e;
    for (int p = 0; p < 32; p++) begin
      bus.DataOutAddress = p[4:0];
      e.a = tb_conv(exp_blk[p]);
      e.b = tb_conv(exp_blk[p + 32]);
      e.addr = p;
      sb_q.push_back(e);
      step();
      e = sb_q.pop_front();
      checks++;
      if (bus.DataOutA !== e.a || bus.DataOutB !== e.b) begin
        errors++;
        $display("FAIL %s pair=%0d got A=%0d B=%0d want A=%0d B=%0d", name, e.addr,
                 $signed(bus.DataOutA), $signed(bus.DataOutB), $signed(e.a), $signed(e.b));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.DataInit = 1'b0; bus.DataInEnable = 1'b0; bus.DataInAddress = 6'd0;
    bus.DataIn = 16'd0; bus.BlockEnd = 1'b0; bus.BlockColor = 3'd0;
    bus.DataOutAddress = 5'd0; bus.DataOutRead = 1'b0;
    #23;
    chk("rst_ready", int'(bus.DataInReady), 1);
    chk("rst_overflow", int'(bus.Overflow), 0);
    chk("rst_out_en", int'(bus.DataOutEnable), 0);
    chk("rst_color", int'(bus.DataOutColor), 0);
    chk("rst_a", int'(bus.DataOutA), 0);
    chk("rst_b", int'(bus.DataOutB), 0);
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    clear_exp();
    wr(0, 100, 1'b1);
    wr(1, -5, 1'b1);
    wr(2, 7, 1'b1);
    commit(2);
    chk("basic_out_en", int'(bus.DataOutEnable), 1);
    chk("basic_color", int'(bus.DataOutColor), 2);
    chk("basic_raster8", exp_blk[8], 7);
    read_check("basic_block");
    release_blk();
    chk("basic_empty", int'(bus.DataOutEnable), 0);
  endtask

  task automatic test_full_reuse();
    clear_exp();
    wr(5, 9, 1'b1);
    commit(1);
    read_check("full_blk_a_early");
    wr(0, 1, 1'b0);
    commit(3);
    chk("full_ready", int'(bus.DataInReady), 0);
    wr(3, 55, 1'b0);
    chk("full_overflow", int'(bus.Overflow), 1);
    chk("full_head_color", int'(bus.DataOutColor), 1);
    read_check("full_blk_a");
    release_blk();
    chk("full_ready_after_rel", int'(bus.DataInReady), 1);
    chk("full_head2_color", int'(bus.DataOutColor), 3);
    wr(0, 1, 1'b0);
    commit(4);
    clear_exp();
    exp_blk[0] = 1;
    read_check("full_blk_b");
    release_blk();
    chk("reuse_color", int'(bus.DataOutColor), 4);
    read_check("reuse_blk");
    release_blk();
    chk("reuse_empty", int'(bus.DataOutEnable), 0);
    chk("overflow_sticky", int'(bus.Overflow), 1);
  endtask

  task automatic test_commit_release();
    bus.DataInit = 1'b1;
    step();
    bus.DataInit = 1'b0;
    chk("cr_init_ovf", int'(bus.Overflow), 0);
    clear_exp();
    wr(10, -3, 1'b1);
    commit(5);
    clear_exp();
    wr(63, 1234, 1'b1);
    commit(6);
    chk("cr_full", int'(bus.DataInReady), 0);
    bus.BlockEnd = 1'b1;
    bus.BlockColor = 3'd7;
    bus.DataOutRead = 1'b1;
    step();
    bus.BlockEnd = 1'b0;
    bus.DataOutRead = 1'b0;
    chk("cr_still_full", int'(bus.DataInReady), 0);
    chk("cr_out_en", int'(bus.DataOutEnable), 1);
    chk("cr_head_color", int'(bus.DataOutColor), 6);
    chk("cr_no_ovf", int'(bus.Overflow), 0);
    read_check("cr_blk_b");
    release_blk();
    chk("cr_new_color", int'(bus.DataOutColor), 7);
    clear_exp();
    read_check("cr_blk_c");
    release_blk();
    chk("cr_empty", int'(bus.DataOutEnable), 0);
  endtask

  task automatic test_width();
    int exp_a0;
`ifdef AQ_DJPEG_COEF_SAT_EN
    exp_a0 = 2047;
`else
    exp_a0 = -1096;
`endif
    clear_exp();
    wr(0, 3000, 1'b1);
    wr(1, -3000, 1'b1);
    wr(2, 2047, 1'b1);
    wr(3, -2048, 1'b1);
    commit(0);
    bus.DataOutAddress = 5'd0;
    step();
    chk("width_3000", int'($signed(bus.DataOutA)), exp_a0);
    read_check("width_blk");
    release_blk();
  endtask

  task automatic test_init();
    clear_exp();
    wr(0, 5, 1'b0);
    commit(1);
    wr(1, 6, 1'b0);
    commit(2);
    wr(2, 8, 1'b0);
    chk("init_pre_ovf", int'(bus.Overflow), 1);
    release_blk();
    for (int k = 0; k < 10; k++) wr(k, k + 20, 1'b0);
    bus.DataInit = 1'b1;
    bus.DataInEnable = 1'b1;
    bus.DataInAddress = 6'd20;
    bus.DataIn = 16'd99;
    bus.BlockEnd = 1'b1;
    bus.BlockColor = 3'd6;
    bus.DataOutRead = 1'b1;
    step();
    bus.DataInit = 1'b0;
    bus.DataInEnable = 1'b0;
    bus.BlockEnd = 1'b0;
    bus.DataOutRead = 1'b0;
    chk("init_out_en", int'(bus.DataOutEnable), 0);
    chk("init_ready", int'(bus.DataInReady), 1);
    chk("init_ovf", int'(bus.Overflow), 0);
    chk("init_color", int'(bus.DataOutColor), 0);
    clear_exp();
    wr(0, 11, 1'b1);
    commit(1);
    chk("init_next_en", int'(bus.DataOutEnable), 1);
    chk("init_next_color", int'(bus.DataOutColor), 1);
    read_check("init_clean_blk");
    release_blk();
    chk("init_count_zero", int'(bus.DataOutEnable), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_full_reuse();
    test_commit_release();
    test_width();
    test_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
